// File: rtl/fullconn_layer_sc_pkg.sv
// fcsc_pkg: shared helpers for the stochastic fully connected layer.
//   clog2            : ceiling log2 used to size the sum and window counter
//   s_mid_lo/s_mid_hi: the two state-counter midpoints used for (re)seeding
//   zp_lo/zp_hi      : bounds of the two middle quarters that drive zp
package fcsc_pkg;

   function automatic int clog2(input int v);
      int r;
      int x;
      r = 0;
      x = v - 1;
      while (x > 0) begin
         r = r + 1;
         x = x >> 1;
      end
      return r;
   endfunction

   function automatic int s_mid_lo(input int m);
      return (1 << (m - 1)) - 1;
   endfunction

   function automatic int s_mid_hi(input int m);
      return 1 << (m - 1);
   endfunction

   function automatic int zp_lo(input int m);
      return 1 << (m - 2);
   endfunction

   function automatic int zp_hi(input int m);
      return 3 * (1 << (m - 2));
   endfunction

endpackage

// File: rtl/fullconn_layer_sc_if.sv
// fcsc_if: groups the layer's stream/config inputs and its stream/count outputs.
//   slave  : seen by the layer (inputs in, z/zp/a_out/cnt_out/cnt_valid out)
//   master : seen by the driver of the layer (upstream layer or bench)
interface fcsc_if #(
   parameter int N_IN  = 8,
   parameter int N_OUT = 5,
   parameter int CW    = 9
) ();
   logic                    EN;
   logic                    CLK_TRAINING_flag;
   logic [N_IN-1:0]         a_input;
   logic [N_OUT*N_IN-1:0]   alpha;
   logic [N_OUT*N_IN-1:0]   SIGN_alpha;
   logic [N_OUT-1:0]        beta;
   logic [N_OUT-1:0]        SIGN_beta;
   logic [N_OUT-1:0]        a_MEM_ACTIVE;
   logic [N_OUT-1:0]        z;
   logic [N_OUT-1:0]        zp;
   logic [N_OUT-1:0]        a_out;
   logic [N_OUT*CW-1:0]     cnt_out;
   logic                    cnt_valid;

   modport slave (
      input  EN, CLK_TRAINING_flag, a_input, alpha, SIGN_alpha, beta, SIGN_beta, a_MEM_ACTIVE,
      output z, zp, a_out, cnt_out, cnt_valid
   );

   modport master (
      output EN, CLK_TRAINING_flag, a_input, alpha, SIGN_alpha, beta, SIGN_beta, a_MEM_ACTIVE,
      input  z, zp, a_out, cnt_out, cnt_valid
   );
endinterface

// File: rtl/fullconn_layer_sc_node.sv
// sc_node: one stochastic neuron.
//   i_a/i_alpha/i_sign_alpha : input streams with this node's weight bits/signs
//   i_beta/i_sign_beta       : bias bit and sign
//   i_en/i_flag/i_mem_active : advance, re-seed, re-seed polarity
//   i_win_end                : EN cycle on which the shared window closes
//   o_z/o_zp/o_a_out         : activation, derivative, delayed activation
//   o_cnt                    : ones-count of a_out over the last complete window
module sc_node
   import fcsc_pkg::*;
#(
   parameter int N_IN    = 8,
   parameter int MEMSIZE = 3,
   parameter int CW      = 9
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_en,
   input  logic              i_flag,
   input  logic              i_mem_active,
   input  logic              i_win_end,
   input  logic [N_IN-1:0]   i_a,
   input  logic [N_IN-1:0]   i_alpha,
   input  logic [N_IN-1:0]   i_sign_alpha,
   input  logic              i_beta,
   input  logic              i_sign_beta,
   output logic              o_z,
   output logic              o_zp,
   output logic              o_a_out,
   output logic [CW-1:0]     o_cnt
);
   localparam int SW = clog2(N_IN + 2) + 1;
   // Headroom so S + sum never overflows before the clamp.
   localparam int XW = ((SW > MEMSIZE) ? SW : MEMSIZE) + 2;
   localparam logic signed [XW-1:0] S_MAX  = XW'((1 << MEMSIZE) - 1);
   localparam logic [MEMSIZE-1:0]   S_LO   = MEMSIZE'(s_mid_lo(MEMSIZE));
   localparam logic [MEMSIZE-1:0]   S_HI   = MEMSIZE'(s_mid_hi(MEMSIZE));
   localparam logic [MEMSIZE:0]     ZP_LO  = (MEMSIZE+1)'(zp_lo(MEMSIZE));
   localparam logic [MEMSIZE:0]     ZP_HI  = (MEMSIZE+1)'(zp_hi(MEMSIZE));

   logic signed [SW-1:0] w_sum;
   logic signed [XW-1:0] w_ext;
   logic [MEMSIZE-1:0]   w_s_next;
   logic [MEMSIZE-1:0]   r_s;
   logic                 r_a_out;
   logic [CW-1:0]        r_acc;
   logic [CW-1:0]        r_cnt;

   always_comb begin
      w_sum = '0;
      for (int i = 0; i < N_IN; i++) begin
         if (i_a[i] && i_alpha[i]) begin
            w_sum = i_sign_alpha[i] ? (w_sum - SW'(1)) : (w_sum + SW'(1));
         end
      end
      if (i_beta) begin
         w_sum = i_sign_beta ? (w_sum - SW'(1)) : (w_sum + SW'(1));
      end
      w_ext = XW'(signed'({1'b0, r_s})) + XW'(w_sum);
      if (w_ext < 0) begin
         w_s_next = '0;
      end else if (w_ext > S_MAX) begin
         w_s_next = '1;
      end else begin
         w_s_next = w_ext[MEMSIZE-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s     <= S_LO;
         r_a_out <= 1'b0;
         r_acc   <= '0;
         r_cnt   <= '0;
      end else if (i_flag) begin
         r_s     <= i_mem_active ? S_HI : S_LO;
         r_a_out <= i_mem_active;
         r_acc   <= '0;
      end else if (i_en) begin
         r_s     <= w_s_next;
         r_a_out <= r_s[MEMSIZE-1];
         // The closing cycle's a_out still belongs to the window being reported.
         if (i_win_end) begin
            r_cnt <= r_acc + CW'(r_a_out);
            r_acc <= '0;
         end else begin
            r_acc <= r_acc + CW'(r_a_out);
         end
      end
   end

   assign o_z     = r_s[MEMSIZE-1];
   assign o_zp    = ({1'b0, r_s} >= ZP_LO) && ({1'b0, r_s} < ZP_HI);
   assign o_a_out = r_a_out;
   assign o_cnt   = r_cnt;
endmodule

// File: rtl/fullconn_layer_sc.sv
// fullconn_layer_sc: stochastic fully connected layer, N_IN streams into N_OUT neurons.
//   CLK, INIT : clock and synchronous active-high reset
//   bus       : fcsc_if slave (EN, re-seed flag, streams, weights in; z/zp/a_out,
//               windowed counts and their valid pulse out)
// The window counter is shared so all node counts close on the same cycle.
module fullconn_layer_sc
   import fcsc_pkg::*;
#(
   parameter int N_IN    = 8,
   parameter int N_OUT   = 5,
   parameter int MEMSIZE = 3,
   parameter int WINDOW  = 256,
   parameter int CW      = 9
) (
   input  logic  CLK,
   input  logic  INIT,
   fcsc_if.slave bus
);
   localparam int WCW = clog2(WINDOW);

   logic [WCW-1:0] r_wc;
   logic           r_cnt_valid;
   logic           w_win_end;

   assign w_win_end = bus.EN && (r_wc == WCW'(WINDOW - 1));

   always_ff @(posedge CLK) begin
      if (INIT || bus.CLK_TRAINING_flag) begin
         r_wc        <= '0;
         r_cnt_valid <= 1'b0;
      end else if (bus.EN) begin
         r_cnt_valid <= w_win_end;
         r_wc        <= w_win_end ? '0 : (r_wc + WCW'(1));
      end else begin
         r_cnt_valid <= 1'b0;
      end
   end

   assign bus.cnt_valid = r_cnt_valid;

   for (genvar j = 0; j < N_OUT; j++) begin : g_node
      logic          w_z;
      logic          w_zp;
      logic          w_a_out;
      logic [CW-1:0] w_cnt;

      sc_node #(
         .N_IN    (N_IN),
         .MEMSIZE (MEMSIZE),
         .CW      (CW)
      ) u_node (
         .clk          (CLK),
         .rst          (INIT),
         .i_en         (bus.EN),
         .i_flag       (bus.CLK_TRAINING_flag),
         .i_mem_active (bus.a_MEM_ACTIVE[j]),
         .i_win_end    (w_win_end),
         .i_a          (bus.a_input),
         .i_alpha      (bus.alpha[j*N_IN +: N_IN]),
         .i_sign_alpha (bus.SIGN_alpha[j*N_IN +: N_IN]),
         .i_beta       (bus.beta[j]),
         .i_sign_beta  (bus.SIGN_beta[j]),
         .o_z          (w_z),
         .o_zp         (w_zp),
         .o_a_out      (w_a_out),
         .o_cnt        (w_cnt)
      );

      assign bus.z[j]                = w_z;
      assign bus.zp[j]               = w_zp;
      assign bus.a_out[j]            = w_a_out;
      assign bus.cnt_out[j*CW +: CW] = w_cnt;
   end
endmodule

// File: tb/tb_fullconn_layer_sc.sv
module tb_fullconn_layer_sc;
   localparam int NI  = 2;
   localparam int NO  = 2;
   localparam int M   = 3;
   localparam int W   = 4;
   localparam int CWB = 3;

   typedef struct {
      logic [NO-1:0]     z;
      logic [NO-1:0]     zp;
      logic [NO-1:0]     a;
      logic              cv;
      logic [NO*CWB-1:0] cnt;
   } exp_t;

   logic clk;
   logic init;
   exp_t q[$];
   int   checks;
   int   errors;
   int   cyc;

   // reference model state
   int ms[NO];
   int maout[NO];
   int macc[NO];
   int mcnt[NO];
   int mwc;
   int mcv;

   fcsc_if #(.N_IN(NI), .N_OUT(NO), .CW(CWB)) bus ();

   fullconn_layer_sc #(
      .N_IN(NI), .N_OUT(NO), .MEMSIZE(M), .WINDOW(W), .CW(CWB)
   ) dut (
      .CLK  (clk),
      .INIT (init),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int zbit(input int s);
      return (s >= (1 << (M - 1))) ? 1 : 0;
   endfunction

   function automatic int zpbit(input int s);
      return ((s >= (1 << (M - 2))) && (s < 3 * (1 << (M - 2)))) ? 1 : 0;
   endfunction

   task automatic step(input bit en, input bit ini, input bit flag,
                       input logic [NI-1:0] a, input logic [NO*NI-1:0] al,
                       input logic [NO*NI-1:0] sal, input logic [NO-1:0] be,
                       input logic [NO-1:0] sbe, input logic [NO-1:0] mact);
      exp_t e;
      int   sum;
      int   ns;
      int   old_z;
      bit   close;
      @(negedge clk);
      init                  = ini;
      bus.EN                = en;
      bus.CLK_TRAINING_flag = flag;
      bus.a_input           = a;
      bus.alpha             = al;
      bus.SIGN_alpha        = sal;
      bus.beta              = be;
      bus.SIGN_beta         = sbe;
      bus.a_MEM_ACTIVE      = mact;
      if (ini) begin
         for (int j = 0; j < NO; j++) begin
            ms[j] = (1 << (M - 1)) - 1; maout[j] = 0; macc[j] = 0; mcnt[j] = 0;
         end
         mwc = 0; mcv = 0;
      end else if (flag) begin
         for (int j = 0; j < NO; j++) begin
            ms[j]    = mact[j] ? (1 << (M - 1)) : (1 << (M - 1)) - 1;
            maout[j] = mact[j] ? 1 : 0;
            macc[j]  = 0;
         end
         mwc = 0; mcv = 0;
      end else if (en) begin
         close = (mwc == W - 1);
         for (int j = 0; j < NO; j++) begin
            sum = 0;
            for (int i = 0; i < NI; i++)
               if (a[i] && al[j*NI+i]) sum += sal[j*NI+i] ? -1 : 1;
            if (be[j]) sum += sbe[j] ? -1 : 1;
            ns = ms[j] + sum;
            if (ns < 0) ns = 0;
            if (ns > (1 << M) - 1) ns = (1 << M) - 1;
            old_z = zbit(ms[j]);
            if (close) begin
               mcnt[j] = macc[j] + maout[j];
               macc[j] = 0;
            end else begin
               macc[j] = macc[j] + maout[j];
            end
            ms[j]    = ns;
            maout[j] = old_z;
         end
         mcv = close ? 1 : 0;
         mwc = close ? 0 : mwc + 1;
      end else begin
         mcv = 0;
      end
      for (int j = 0; j < NO; j++) begin
         e.z[j]  = 1'(zbit(ms[j]));
         e.zp[j] = 1'(zpbit(ms[j]));
         e.a[j]  = 1'(maout[j]);
         e.cnt[j*CWB +: CWB] = CWB'(mcnt[j]);
      end
      e.cv = 1'(mcv);
      q.push_back(e);
   endtask

   // monitor: every cycle the DUT presents outputs; compare against the oldest expectation
   initial begin
      exp_t e;
      cyc = 0;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (bus.z !== e.z || bus.zp !== e.zp || bus.a_out !== e.a ||
                bus.cnt_valid !== e.cv || bus.cnt_out !== e.cnt) begin
               errors++;
               $display("FAIL outputs cyc=%0d got z=%b zp=%b a_out=%b cv=%b cnt=%h exp z=%b zp=%b a_out=%b cv=%b cnt=%h",
                        cyc, bus.z, bus.zp, bus.a_out, bus.cnt_valid, bus.cnt_out,
                        e.z, e.zp, e.a, e.cv, e.cnt);
            end
         end
      end
   end

   initial begin
      logic [NI-1:0]    ones_a;
      logic [NO*NI-1:0] ones_al;
      logic [NO-1:0]    ones_b;
      int               guard;
      checks = 0;
      errors = 0;
      ones_a  = '1;
      ones_al = '1;
      ones_b  = '1;
      init = 1'b1;
      bus.EN = 1'b0; bus.CLK_TRAINING_flag = 1'b0; bus.a_input = '0;
      bus.alpha = '0; bus.SIGN_alpha = '0; bus.beta = '0; bus.SIGN_beta = '0;
      bus.a_MEM_ACTIVE = '0;

      // reset held two cycles
      repeat (2) step(1, 1, 0, '0, '0, '0, '0, '0, '0);
      // +3 per cycle: saturate high
      repeat (3) step(1, 0, 0, ones_a, ones_al, '0, ones_b, '0, '0);
      // -3 per cycle: saturate at zero, no wrap
      repeat (4) step(1, 0, 0, ones_a, ones_al, ones_al, ones_b, ones_b, '0);
      // saturated high node gives constant a_out=1 windows, then EN gap
      repeat (12) step(1, 0, 0, ones_a, ones_al, '0, ones_b, '0, '0);
      repeat (3)  step(0, 0, 0, ones_a, ones_al, '0, ones_b, '0, '0);
      repeat (10) step(1, 0, 0, ones_a, ones_al, '0, ones_b, '0, '0);
      // re-seed at wc=2 with active polarity
      guard = 0;
      while (mwc != 2 && guard < 8) begin
         step(1, 0, 0, ones_a, ones_al, '0, ones_b, '0, '0);
         guard++;
      end
      step(0, 0, 1, '0, '0, '0, '0, '0, ones_b);
      repeat (9) step(1, 0, 0, '0, '0, '0, '0, '0, '0);
      // mixed polarity re-seed
      step(1, 0, 1, '0, '0, '0, '0, '0, 2'b01);
      repeat (3) step(1, 0, 0, '0, '0, '0, '0, '0, '0);
      // INIT wins over re-seed
      step(1, 1, 1, ones_a, ones_al, '0, ones_b, '0, ones_b);
      repeat (2) step(1, 0, 0, '0, '0, '0, '0, '0, '0);
      // randomized traffic
      for (int k = 0; k < 400; k++) begin
         step($urandom_range(0, 9) != 0, $urandom_range(0, 149) == 0,
              $urandom_range(0, 59) == 0, NI'($urandom), (NO*NI)'($urandom),
              (NO*NI)'($urandom), NO'($urandom), NO'($urandom), NO'($urandom));
      end

      guard = 0;
      while (q.size() > 0 && guard < 10) begin
         @(posedge clk);
         guard++;
      end
      #2;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain pending=%0d required=0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/fullconn_layer_sc.md
Name: fullconn_layer_sc

Overview:
- Parametrised stochastic-computing fully connected layer: N_IN bipolar input bitstreams feed N_OUT neurons.
- Each neuron combines signed weight and bias streams, drives a saturating state counter (stochastic tanh), and emits z/zp/a_out streams.
- Adds per-node windowed ones-counters with a valid pulse for readout/training; earlier layers had none.
- Sits between adjacent layers in the SNN pipeline; replaces the fixed 8-in/5-out layer blocks.

Parameters:
- N_IN, 8, input streams per node
- N_OUT, 5, neurons in layer
- MEMSIZE, 3, state counter width M; states 0..2^M-1
- WINDOW, 256, cycles per observation window (>=2)
- CW, 9, count width; must satisfy 2^CW > WINDOW

Ports:
- CLK  in  1  clock
- INIT  in  1  synchronous active-high reset
- EN  in  1  advance enable; low freezes all state
- CLK_TRAINING_flag  in  1  synchronous node re-seed and window restart
- a_input  in  N_IN  input bitstreams
- alpha  in  N_OUT*N_IN  weight magnitude bits; node j, input i at bit j*N_IN+i
- SIGN_alpha  in  N_OUT*N_IN  weight sign, 1 = negative
- beta  in  N_OUT  bias magnitude bits
- SIGN_beta  in  N_OUT  bias sign
- a_MEM_ACTIVE  in  N_OUT  re-seed polarity per node
- z  out  N_OUT  activation stream = MSB of state
- zp  out  N_OUT  derivative stream
- a_out  out  N_OUT  z registered one cycle, to next layer
- cnt_out  out  N_OUT*CW  ones-count of a_out per node, last complete window
- cnt_valid  out  1  one-cycle pulse when cnt_out updates

Behaviour:
- Per node j, each cycle: term_i = a_input[i] & alpha[j,i], sign +1/-1 per SIGN_alpha; bias term = beta[j] with SIGN_beta[j].
- sum = signed total in -(N_IN+1)..+(N_IN+1), width clog2(N_IN+2)+1.
- State S (M bits): S <= clamp(S + sum, 0, 2^M-1) when EN. Saturation is mandatory; no wrap-around.
- z = S[M-1].
- zp = 1 when 2^(M-2) <= S < 3*2^(M-2), i.e. the two middle quarters; for M=3, S in 2..5.
- a_out <= z each EN cycle (1-cycle latency).
- Window counter wc runs 0..WINDOW-1. Per-node acc increments when a_out=1.
- On the EN cycle with wc=WINDOW-1: cnt_out <= acc + a_out, acc <= 0, wc <= 0, cnt_valid=1 next cycle.
- cnt_valid is otherwise 0.
- EN=0: S, a_out, wc, acc hold; cnt_valid=0.
- INIT (priority over everything): S=2^(M-1)-1, a_out=0, wc=0, acc=0, cnt_out=0, cnt_valid=0.
- CLK_TRAINING_flag (no INIT):
  - S = 2^(M-1) if a_MEM_ACTIVE[j] else 2^(M-1)-1.
  - a_out = a_MEM_ACTIVE[j]; wc=0; acc=0.
  - cnt_out holds; cnt_valid=0. A window in progress is discarded.
  - Acts regardless of EN.
- Reset/flag mid-window: discard partial count; no valid pulse.

Decomposition:
- Package fcsc_pkg: clog2 function, state-midpoint constants, zp quarter bounds.
- Sub-module sc_node: one neuron with sum, saturating S, z/zp, a_out, acc.
- Top level: generate loop over N_OUT plus the shared window counter and cnt_valid.

Test Plan:
- N_IN=2, M=3, INIT held 2 cycles -> S=3, z=0, zp=1, a_out=0, cnt_out=0, cnt_valid=0.
- All a_input=1, alpha=1, SIGN=0, beta=1 (+3/cycle) from S=3 -> S 6 then 7, saturates at 7. z=1 from cycle 1; zp=0 once S>=6.
- All weights SIGN=1 -> S reaches 0 and holds, no underflow wrap; z=0.
- WINDOW=4, a_out forced constant 1 via saturated node -> cnt_valid pulses every 4 EN cycles with cnt_out=4. EN low 3 cycles mid-window -> pulse delayed by exactly 3.
- CLK_TRAINING_flag at wc=2 with a_MEM_ACTIVE=1 -> S=4, a_out=1, no pulse; next pulse 4 EN cycles later.
- INIT and CLK_TRAINING_flag asserted together -> INIT values (S=3, a_out=0).
